// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: load opcodes, controller states and
// the access-size helper used for alignment checks.
package lsu_pkg;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LD  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;
  localparam logic [2:0] LD_LWU = 3'd6;

  typedef enum logic [2:0] {
    OP_LB   = 3'd0,
    OP_LH   = 3'd1,
    OP_LW   = 3'd2,
    OP_LD   = 3'd3,
    OP_LBU  = 3'd4,
    OP_LHU  = 3'd5,
    OP_LWU  = 3'd6,
    OP_RSVD = 3'd7
  } load_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } state_e;

  // Access size in bytes; funct3[1:0] encodes log2(size) for all loads.
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ld_extend.sv
// Load lane formatter: shifts a double-word window right by the byte
// offset, keeps the accessed lane and sign- or zero-extends it to DATA_W.
module lsu_ld_extend
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [2*DATA_W-1:0] din,
  input  logic [OFF_W-1:0]    offset,
  input  logic [2:0]          funct3,
  output logic [DATA_W-1:0]   dout
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sgn;

  // Extension as mask-and-fill so one body serves both data widths; a lane
  // as wide as DATA_W yields an all-ones mask and no fill.
  always_comb begin
    shifted = DATA_W'(din >> {offset, 3'b000});
    mask    = '1;
    sgn     = 1'b0;
    case (funct3)
      LD_LB:  begin mask = DATA_W'(64'hFF);        sgn = shifted[7];  end
      LD_LH:  begin mask = DATA_W'(64'hFFFF);      sgn = shifted[15]; end
      LD_LW:  begin mask = DATA_W'(64'hFFFF_FFFF); sgn = shifted[31]; end
      LD_LBU: mask = DATA_W'(64'hFF);
      LD_LHU: mask = DATA_W'(64'hFFFF);
      LD_LWU: mask = DATA_W'(64'hFFFF_FFFF);
      default: mask = '1;
    endcase
    dout = (shifted & mask) | (sgn ? ~mask : '0);
  end

endmodule

// File: rtl/lsu_load_ctrl.sv
// Sequential LSU load path: one outstanding load, aligned word read over a
// valid/ready memory port, lane extraction and extension of the result.
// Optional build macro LSU_MISALIGN_SPLIT_EN: misaligned loads are serviced
// (two reads when crossing a word) instead of returning an error.
module lsu_load_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  state_e              state;
  logic [OFF_W-1:0]    off_q;
  logic [2:0]          f3_q;
  logic [OFF_W-1:0]    req_off;
  logic [ADDR_W-1:0]   req_aligned;
  logic [3:0]          nbytes;
  logic [3:0]          off_ext;
  logic                illegal;
  logic                misaligned;
  logic [2*DATA_W-1:0] ext_in;
  logic [DATA_W-1:0]   lane;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic                crosses;
  logic                split_q;
  logic [DATA_W-1:0]   lo_q;
`endif

  assign req_ready   = (state == S_IDLE);
  assign req_off     = req_addr[OFF_W-1:0];
  assign req_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Classify the incoming request: legality, alignment and word crossing.
  always_comb begin
    nbytes     = access_bytes(req_funct3);
    off_ext    = 4'(req_off);
    misaligned = (off_ext & (nbytes - 4'd1)) != 4'd0;
    case (load_op_e'(req_funct3))
      OP_RSVD:       illegal = 1'b1;
      OP_LD, OP_LWU: illegal = (DATA_W == 32);
      default:       illegal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    crosses = (5'(off_ext) + 5'(nbytes)) > 5'(NB);
`endif
  end

  // Extender window: {hi, lo} after a split read, otherwise the single word.
  always_comb begin
    ext_in               = '0;
    ext_in[DATA_W-1:0]   = mem_rsp_data;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state == S_WAIT1) ext_in = {mem_rsp_data, lo_q};
`endif
  end

  lsu_ld_extend #(.DATA_W(DATA_W)) u_extend (
    .din    (ext_in),
    .offset (off_q),
    .funct3 (f3_q),
    .dout   (lane)
  );

  // Load controller FSM with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      off_q         <= '0;
      f3_q          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      lo_q          <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            off_q <= req_off;
            f3_q  <= req_funct3;
            if (illegal) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else begin
              state         <= S_REQ0;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= req_aligned;
              split_q       <= misaligned && crosses;
            end
`else
            else if (misaligned) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state         <= S_REQ0;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= req_aligned;
            end
`endif
          end
        end
        S_REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (split_q) begin
              lo_q          <= mem_rsp_data;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + ADDR_W'(NB);
              state         <= S_REQ1;
            end else
`endif
            begin
              rsp_data  <= lane;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (mem_rsp_valid) begin
            rsp_data  <= lane;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_load_ctrl.sv
// Directed bench for lsu_load_ctrl: a 32-bit and a 64-bit instance share one
// stimulus driver; a small word memory answers the read port.
module tb_lsu_load_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        rsp_ready;

  logic        rr32, mv32, rv32, re32;
  logic [31:0] ma32, rd32;
  logic        rr64, mv64, rv64, re64;
  logic [31:0] ma64;
  logic [63:0] rd64;

  logic        o_req_ready, o_mem_req_valid, o_rsp_valid, o_rsp_err;
  logic [31:0] o_mem_req_addr;
  logic [63:0] o_rsp_data;

  logic [63:0] mem [16];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  assign o_req_ready     = sel ? rr64 : rr32;
  assign o_mem_req_valid = sel ? mv64 : mv32;
  assign o_mem_req_addr  = sel ? ma64 : ma32;
  assign o_rsp_valid     = sel ? rv64 : rv32;
  assign o_rsp_err       = sel ? re64 : re32;
  assign o_rsp_data      = sel ? rd64 : {32'h0, rd32};

  lsu_load_ctrl #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rr32),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_req_valid(mv32), .mem_req_ready(mem_req_ready & ~sel),
    .mem_req_addr(ma32),
    .mem_rsp_valid(mem_rsp_valid & ~sel), .mem_rsp_data(mem_rsp_data[31:0]),
    .rsp_valid(rv32), .rsp_ready(rsp_ready & ~sel),
    .rsp_data(rd32), .rsp_err(re32)
  );

  lsu_load_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rr64),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_req_valid(mv64), .mem_req_ready(mem_req_ready & sel),
    .mem_req_addr(ma64),
    .mem_rsp_valid(mem_rsp_valid & sel), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rv64), .rsp_ready(rsp_ready & sel),
    .rsp_data(rd64), .rsp_err(re64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one load and play memory/consumer, with optional stalls.
  task automatic run(input bit w64, input logic [31:0] addr, input logic [2:0] f3,
                     input int unsigned stall_n, input int unsigned hold_n,
                     output logic [63:0] data, output logic err,
                     output int unsigned lat, output int unsigned nreq,
                     output logic [31:0] maddr, output bit stable_ok);
    bit          pend = 0, done = 0, seen_rsp = 0, prev_wait = 0;
    logic [3:0]  pidx = '0;
    logic [31:0] prev_addr = '0;
    logic [63:0] first_data = '0;
    int unsigned stall = stall_n, hold = hold_n;
    data = '0; err = 1'bx; lat = 0; nreq = 0; maddr = '0; stable_ok = 1;
    @(negedge clk);
    sel = w64; req_addr = addr; req_funct3 = f3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int unsigned c = 1; c <= 60 && !done; c++) begin
      mem_rsp_valid = 1'b0;
      if (pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem[pidx];
        pend = 0;
      end
      if (o_req_ready) stable_ok = 0;
      mem_req_ready = 1'b0;
      if (o_mem_req_valid) begin
        if (prev_wait && o_mem_req_addr !== prev_addr) stable_ok = 0;
        prev_addr = o_mem_req_addr;
        if (stall > 0) begin
          stall--;
          prev_wait = 1;
        end else begin
          mem_req_ready = 1'b1;
          prev_wait = 0;
          pend = 1;
          pidx = w64 ? o_mem_req_addr[6:3] : o_mem_req_addr[5:2];
          nreq++;
          if (nreq == 1) maddr = o_mem_req_addr;
        end
      end else prev_wait = 0;
      rsp_ready = 1'b0;
      if (o_rsp_valid) begin
        if (!seen_rsp) begin
          seen_rsp = 1; lat = c; first_data = o_rsp_data;
        end else if (o_rsp_data !== first_data) stable_ok = 0;
        if (hold > 0) hold--;
        else begin
          rsp_ready = 1'b1; data = o_rsp_data; err = o_rsp_err; done = 1;
        end
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    if (!done) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic load(input string tag, input bit w64, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [63:0] exp_data,
                      input logic exp_err, input int unsigned exp_nreq);
    logic [63:0] d; logic e; int unsigned lat, nr; logic [31:0] ma; bit ok;
    run(w64, addr, f3, 0, 0, d, e, lat, nr, ma, ok);
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
    chk({tag, "_nreq"}, 64'(nr), 64'(exp_nreq));
    chk({tag, "_rdy_back"}, 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] d; logic e; int unsigned lat, nr; logic [31:0] ma; bit ok;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(rr32), 64'd1);
    chk("rst_mem_valid", 64'(mv32), 64'd0);
    chk("rst_mem_addr", 64'(ma32), 64'd0);
    chk("rst_rsp_valid", 64'(rv32), 64'd0);
    chk("rst_rsp_data", 64'(rd32), 64'd0);
    chk("rst_rsp_err", 64'(re32), 64'd0);
    chk("rst_req_ready64", 64'(rr64), 64'd1);

    // LB at byte 3: minimum latency and aligned memory address
    mem[0] = 64'h80FF_1234;
    run(0, 32'h103, LD_LB, 0, 0, d, e, lat, nr, ma, ok);
    chk("lb_data", d, 64'hFFFF_FF80);
    chk("lb_err", 64'(e), 64'd0);
    chk("lb_lat", 64'(lat), 64'd3);
    chk("lb_maddr", 64'(ma), 64'h100);

    mem[0] = 64'hBEEF_0000;
    run(0, 32'h102, LD_LHU, 0, 0, d, e, lat, nr, ma, ok);
    chk("lhu_data", d, 64'h0000_BEEF);
    chk("lhu_maddr", 64'(ma), 64'h100);
    load("lh", 0, 32'h102, LD_LH, 64'hFFFF_BEEF, 0, 1);

    // Misaligned accesses
    mem[0] = 64'h4433_2211;
    mem[1] = 64'h8877_6655;
`ifdef LSU_MISALIGN_SPLIT_EN
    load("lw_split", 0, 32'h101, LD_LW, 64'h5544_3322, 0, 2);
    load("lh_inword", 0, 32'h101, LD_LH, 64'h0000_3322, 0, 1);
`else
    run(0, 32'h101, LD_LW, 0, 0, d, e, lat, nr, ma, ok);
    chk("lw_mis_data", d, 64'd0);
    chk("lw_mis_err", 64'(e), 64'd1);
    chk("lw_mis_nreq", 64'(nr), 64'd0);
    chk("lw_mis_lat", 64'(lat), 64'd1);
    load("lh_mis", 0, 32'h101, LD_LH, 64'd0, 1, 0);
`endif
    load("lbu_off1", 0, 32'h101, LD_LBU, 64'h22, 0, 1);

    // Illegal encodings on the 32-bit instance
    load("ld_on32", 0, 32'h100, 3'd3, 64'd0, 1, 0);
    load("lwu_on32", 0, 32'h100, 3'd6, 64'd0, 1, 0);
    load("f3_7", 0, 32'h100, 3'd7, 64'd0, 1, 0);

    // 64-bit instance
    mem[0] = 64'h8000_0001_0000_0000;
    load("lwu64", 1, 32'h4, LD_LWU, 64'h0000_0000_8000_0001, 0, 1);
    load("lw64", 1, 32'h4, LD_LW, 64'hFFFF_FFFF_8000_0001, 0, 1);
    mem[0] = 64'h8011_2233_4455_6677;
    load("lb64_off7", 1, 32'h7, LD_LB, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    mem[0] = 64'h0123_4567_89AB_CDEF;
    load("ld64", 1, 32'h0, LD_LD, 64'h0123_4567_89AB_CDEF, 0, 1);
    load("f3_7_64", 1, 32'h0, 3'd7, 64'd0, 1, 0);

    // Backpressure on both handshakes
    mem[0] = 64'hDEAD_BEEF;
    run(0, 32'h100, LD_LW, 3, 2, d, e, lat, nr, ma, ok);
    chk("bp_data", d, 64'hDEAD_BEEF);
    chk("bp_stable", 64'(ok), 64'd1);
    chk("bp_lat", 64'(lat), 64'd6);

    // Reset while waiting for the memory response, then a stray response
    @(negedge clk);
    sel = 1'b0; req_addr = 32'h108; req_funct3 = LD_LW; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_mem_valid", 64'(mv32), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_req_ready", 64'(rr32), 64'd1);
    chk("mid_mem_valid0", 64'(mv32), 64'd0);
    chk("mid_mem_addr", 64'(ma32), 64'd0);
    chk("mid_rsp_valid", 64'(rv32), 64'd0);
    chk("mid_rsp_data", 64'(rd32), 64'd0);
    chk("mid_rsp_err", 64'(re32), 64'd0);
    mem[2] = 64'h1122_3344;
    load("after_rst_lh", 0, 32'h10A, LD_LH, 64'h0000_1122, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
